gru_weight_loader: RTL
======================

// Module: gru_weight_loader
// PURPOSE
//  Writer side of the GRU weight/bias memories: takes a 32-bit word stream from the host link and
//  writes it into the bias, input-weight or recurrent-weight array of one GRU layer (gru1/2/3).
//  Replaces static $readmemb initialisation at run time; one instance per GRU layer.
//  Frame = HDR0 {region, count}, HDR1 {start address}, then `count` payload words (IEEE-754 float).
// PARAMETERS
//  float      32     data word width (bits)
//  ADDR_W     16     memory address width
//  BIAS_DEPTH 288    bias array depth (words)
//  IN_DEPTH   32832  input-weight array depth (words)
//  REC_DEPTH  27648  recurrent-weight array depth (words)
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       async active-low reset
//  s_valid      in   1       stream word valid
//  s_ready      out  1       loader can accept a word
//  s_data       in   float   stream word
//  err_clr      in   1       clears load_err (one-cycle pulse)
//  mem_wr_en    out  1       write strobe, one word per cycle
//  mem_wr_sel   out  2       target: 0 bias, 1 input weights, 2 recurrent weights
//  mem_wr_addr  out  ADDR_W  word address within selected array
//  mem_wr_data  out  float   word to write
//  busy         out  1       frame in progress (state != IDLE)
//  load_done    out  1       one-cycle pulse at end of every frame (good or bad)
//  load_err     out  1       sticky error flag
// BEHAVIOUR
//  Reset: state=IDLE; s_ready=1; mem_wr_en=0; mem_wr_sel/addr/data=0; busy=0; load_done=0; load_err=0.
//  Beat accepted when s_valid && s_ready; s_valid may drop between beats, no timeout.
//  HDR0: [31:30] region, [29:16] must be 0, [15:0] count. HDR1: [ADDR_W-1:0] start address, rest ignored.
//  States: IDLE -HDR0-> ADDR -HDR1-> DATA | DRAIN ; DATA/DRAIN -last word-> DONE -> IDLE.
//  Check at HDR1 accept: frame bad if region==3, HDR0[29:16]!=0, count==0, or start+count > depth(region)
//   (sum computed ADDR_W+1 wide, no wrap). Bad frame with count==0 -> DONE directly; else DRAIN.
//  DATA: each accepted beat -> next cycle mem_wr_en=1, addr=start+k (k=0..count-1), data=beat, sel=region.
//  DRAIN: payload consumed, mem_wr_en stays 0; load_err set on entry.
//  DONE: single cycle, s_ready=0, load_done=1; next cycle IDLE, s_ready=1.
//  s_ready=1 in IDLE, ADDR, DATA, DRAIN; write latency 1 cycle, throughput 1 word/cycle.
//  err_clr clears load_err; err_clr in the same cycle as a new error -> load_err stays 1 (set wins).
//  Last address of region (depth-1) is legal; start+count == depth is legal.
//  rst_n low mid-frame: abort immediately, no further writes, no load_done; already-written words stay.
//  Payload remaining counter is 16 bits, counts down to 0; last word = counter==1 on accept.
// STRUCTURE
//  Shared package gru_pkg: region codes (REG_BIAS=0, REG_IN=1, REG_REC=2), state encoding, per-layer
//  depth constants (gru1: 72/1728/1728, gru2: 144/12960/6912, gru3: 288/32832/27648).
//  Single module, no sub-module; one FSM + address/remaining counters + registered write port.
// TESTING
//  1 Reset: hold rst_n=0 5 cycles -> all outputs at reset values, s_ready=1.
//  2 Good bias frame: HDR0=0x0000_0003, HDR1=0x10, data A,B,C back-to-back -> writes sel=0 addr 0x10/0x11/0x12
//    on cycles 1 after each beat; load_done 1 cycle after last write beat; load_err=0.
//  3 Range edge: region 1, start=32830, count=2 -> 2 writes (32830, 32831); count=3 -> no writes, load_err=1,
//    3 payload words drained, load_done pulses.
//  4 Bad header: region=3 count=4 -> 4 words drained, mem_wr_en never 1, load_err=1; err_clr -> load_err=0.
//  5 Gapped valid + reset: region 2 count=8, s_valid toggles each cycle, rst_n pulled low after 3rd beat ->
//    exactly 3 writes (addr start..start+2), no load_done, state IDLE after release.
//  6 count=0 on region 0 -> no DRAIN, load_done next cycle after HDR1, load_err=1, next frame accepted normally.

Source files
------------

// File: rtl/gru_pkg.sv
// Shared GRU loader definitions: region codes, loader states, per-layer depths.
package gru_pkg;

    localparam logic [1:0] REG_BIAS = 2'd0;
    localparam logic [1:0] REG_IN   = 2'd1;
    localparam logic [1:0] REG_REC  = 2'd2;
    localparam logic [1:0] REG_BAD  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int GRU1_BIAS_DEPTH = 72;
    localparam int GRU1_IN_DEPTH   = 1728;
    localparam int GRU1_REC_DEPTH  = 1728;
    localparam int GRU2_BIAS_DEPTH = 144;
    localparam int GRU2_IN_DEPTH   = 12960;
    localparam int GRU2_REC_DEPTH  = 6912;
    localparam int GRU3_BIAS_DEPTH = 288;
    localparam int GRU3_IN_DEPTH   = 32832;
    localparam int GRU3_REC_DEPTH  = 27648;

endpackage

// File: rtl/gru_weight_loader.sv
// Stream-to-memory writer for one GRU layer's bias / input / recurrent arrays.
// Frame: HDR0 {region,count}, HDR1 {start}, then count payload words.
module gru_weight_loader
    import gru_pkg::*;
#(
    parameter int FLOAT_W    = 32,
    parameter int ADDR_W     = 16,
    parameter int BIAS_DEPTH = GRU3_BIAS_DEPTH,
    parameter int IN_DEPTH   = GRU3_IN_DEPTH,
    parameter int REC_DEPTH  = GRU3_REC_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [FLOAT_W-1:0] s_data,
    input  logic               err_clr,
    output logic               mem_wr_en,
    output logic [1:0]         mem_wr_sel,
    output logic [ADDR_W-1:0]  mem_wr_addr,
    output logic [FLOAT_W-1:0] mem_wr_data,
    output logic               busy,
    output logic               load_done,
    output logic               load_err
);

    localparam int SUM_W = ADDR_W + 1;

    state_t             state_q;
    state_t             state_d;
    logic               acc;
    logic [1:0]         region_q;
    logic               rsv_bad_q;
    logic [15:0]        count_q;
    logic [15:0]        rem_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [SUM_W-1:0]   end_sum;
    logic [SUM_W-1:0]   depth;
    logic               hdr_bad;
    logic               last;
    logic               err_set;

    assign acc  = s_valid && s_ready;
    assign last = (rem_q == 16'd1);

    // Range check is done one bit wider than the address so it cannot wrap.
    assign end_sum = {1'b0, s_data[ADDR_W-1:0]} + SUM_W'(count_q);

    always_comb begin
        depth = '0;
        unique case (1'b1)
            region_q == REG_BIAS: depth = SUM_W'(BIAS_DEPTH);
            region_q == REG_IN:   depth = SUM_W'(IN_DEPTH);
            region_q == REG_REC:  depth = SUM_W'(REC_DEPTH);
            region_q == REG_BAD:  depth = '0;
        endcase
    end

    assign hdr_bad = (region_q == REG_BAD) || rsv_bad_q ||
                     (count_q == 16'd0) || (end_sum > depth);

    assign err_set = (state_q == ST_ADDR) && acc && hdr_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (acc) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (acc) begin
                    if (!hdr_bad)
                        state_d = ST_DATA;
                    else if (count_q == 16'd0)
                        state_d = ST_DONE;
                    else
                        state_d = ST_DRAIN;
                end
            end
            ST_DATA, ST_DRAIN: begin
                if (acc && last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready   = (state_q != ST_DONE);
        busy      = (state_q != ST_IDLE);
        load_done = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            region_q  <= '0;
            rsv_bad_q <= 1'b0;
            count_q   <= '0;
            rem_q     <= '0;
            addr_q    <= '0;
        end else if (acc) begin
            unique case (state_q)
                ST_IDLE: begin
                    region_q  <= s_data[31:30];
                    rsv_bad_q <= |s_data[29:16];
                    count_q   <= s_data[15:0];
                end
                ST_ADDR: begin
                    addr_q <= s_data[ADDR_W-1:0];
                    rem_q  <= count_q;
                end
                ST_DATA, ST_DRAIN: begin
                    addr_q <= addr_q + 1'b1;
                    rem_q  <= rem_q - 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en   <= 1'b0;
            mem_wr_sel  <= '0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_wr_en <= acc && (state_q == ST_DATA);
            if (acc && (state_q == ST_DATA)) begin
                mem_wr_sel  <= region_q;
                mem_wr_addr <= addr_q;
                mem_wr_data <= s_data;
            end
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_err <= 1'b0;
        end else if (err_set) begin
            load_err <= 1'b1;
        end else if (err_clr) begin
            load_err <= 1'b0;
        end
    end

endmodule
